// File: rtl/clk_step_pkg.sv
// Shared types and sizing helpers for clk_step_sync.
package clk_step_pkg;

    // Debounce FSM states, 2-bit binary encoding.
    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_QUAL_H = 2'd1,
        ST_HIGH   = 2'd2,
        ST_QUAL_L = 2'd3
    } step_state_e;

    // Ceiling log2 with a floor of 1 bit, for elaboration-time counter sizing.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((r < 31) && ((32'd1 << r) < v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_step_sync_sync_ff.sv
// N-flop synchroniser for a single asynchronous bit, reset to 0.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input into the chain.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Chain register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clk_step_sync.sv
// Step-source synchroniser/debouncer producing one-cycle step enables and a step count.
// Optional free-run divider is built only when CLK_STEP_FREERUN_EN is defined.
module clk_step_sync
    import clk_step_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned RUN_DIV         = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_in,
    input  logic             run_mode,
    output logic             step_en,
    output logic             step_level,
    output logic [CNT_W-1:0] step_cnt
);

    localparam int unsigned DCNT_W = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);

    logic              step_s;
    step_state_e       state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              rise_q, rise_d;
    logic              step_en_q, step_en_d;
    logic              step_level_q, step_level_d;
    logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
    logic              btn_gate_c;
    logic              free_pulse_c;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (step_in),
        .q     (step_s)
    );

`ifdef CLK_STEP_FREERUN_EN
    localparam int unsigned DIV_W = clog2(RUN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;

    // Free-run divider: counts while run_mode is high, cleared otherwise.
    always_comb begin
        div_d = '0;
        if (run_mode) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
    end

    // Divider register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign btn_gate_c   = ~run_mode;
    assign free_pulse_c = run_mode & (div_q == DIV_LAST);
`else
    logic unused_run_mode;
    assign unused_run_mode = run_mode & (RUN_DIV != 0);
    assign btn_gate_c      = 1'b1;
    assign free_pulse_c    = 1'b0;
`endif

    // Debounce FSM: a level change commits only after DEBOUNCE_CYCLES stable samples.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        rise_d  = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (step_s) begin
                    state_d = ST_QUAL_H;
                    dcnt_d  = DCNT_W'(1);
                end
            end
            ST_QUAL_H: begin
                if (!step_s) begin
                    state_d = ST_LOW;
                    dcnt_d  = '0;
                end else if (dcnt_q >= DCNT_LAST) begin
                    state_d = ST_HIGH;
                    dcnt_d  = '0;
                    rise_d  = btn_gate_c;
                end else begin
                    dcnt_d  = dcnt_q + DCNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (!step_s) begin
                    state_d = ST_QUAL_L;
                    dcnt_d  = DCNT_W'(1);
                end
            end
            ST_QUAL_L: begin
                if (step_s) begin
                    state_d = ST_HIGH;
                    dcnt_d  = '0;
                end else if (dcnt_q >= DCNT_LAST) begin
                    state_d = ST_LOW;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d  = dcnt_q + DCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_LOW;
                dcnt_d  = '0;
            end
        endcase
    end

    // Output stage: level from the accepted state, pulse one cycle after the commit.
    always_comb begin
        step_level_d = (state_q == ST_HIGH) || (state_q == ST_QUAL_L);
        step_en_d    = rise_q | free_pulse_c;
        step_cnt_d   = step_cnt_q + CNT_W'(step_en_d);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_LOW;
            dcnt_q       <= '0;
            rise_q       <= 1'b0;
            step_en_q    <= 1'b0;
            step_level_q <= 1'b0;
            step_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            dcnt_q       <= dcnt_d;
            rise_q       <= rise_d;
            step_en_q    <= step_en_d;
            step_level_q <= step_level_d;
            step_cnt_q   <= step_cnt_d;
        end
    end

    assign step_en    = step_en_q;
    assign step_level = step_level_q;
    assign step_cnt   = step_cnt_q;

endmodule
